ray_sphere_nearest: RTL

Multi-object ray/sphere intersection engine: accepts one ray over a valid/ready handshake, scans a parameterised table of up to N_OBJ spheres, and returns the nearest hit distance, object index and colour. Intersection uses the exact discriminant form with a sequential integer square root. It sits between the per-pixel ray generator and the shading/colour stage of the tracer, replacing the single-sphere tracer.

---
 rtl/vtracer_pkg.sv | 41 ++++
 rtl/isqrt_seq.sv | 64 ++++++
 rtl/ray_sphere_nearest.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vtracer_pkg.sv
// Shared field layout, fixed-point constants and FSM states
// for the ray/sphere tracer blocks.
package vtracer_pkg;

    localparam int OBJ_W   = 48;
    localparam int COL_LSB = 36;
    localparam int COL_W   = 12;
    localparam int RAD_LSB = 28;
    localparam int RAD_W   = 8;
    localparam int CX_LSB  = 18;
    localparam int CY_LSB  = 8;
    localparam int CZ_LSB  = 0;
    localparam int XY_W    = 10;
    localparam int Z_W     = 8;

    localparam int ORIG_W  = 28;
    localparam int OX_LSB  = 18;
    localparam int OY_LSB  = 8;
    localparam int OZ_LSB  = 0;

    localparam int DIR_W   = 30;
    localparam int DX_LSB  = 20;
    localparam int DY_LSB  = 10;
    localparam int DZ_LSB  = 0;
    localparam int DC_W    = 10;

    localparam int Q_SHIFT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQRT,
        S_CMP,
        S_DONE
    } state_t;

    function automatic logic signed [31:0] sext_dc(input logic [DC_W-1:0] v);
        return 32'($signed(v));
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per cycle.
// Root is floor(sqrt(radicand)) and is held after done until the next start.
module isqrt_seq #(
    parameter  int ITERS = 8,
    localparam int RW    = 2 * ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RW-1:0]    radicand,
    output logic             busy,
    output logic             done,
    output logic [ITERS-1:0] root
);

    localparam int RMW = ITERS + 2;
    localparam int CW  = $clog2(ITERS) + 1;

    logic [RW-1:0]    rad_q;
    logic [RMW-1:0]   rem_q;
    logic [ITERS-1:0] root_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [RMW-1:0]   rem_sh;
    logic [RMW-1:0]   trial;
    logic             take;

    // remainder stays below 2^ITERS before every step, so the shift never loses bits
    always_comb begin
        rem_sh = (rem_q << 2) | RMW'(rad_q[RW-1 -: 2]);
        trial  = (RMW'(root_q) << 2) | RMW'(1);
        take   = rem_sh >= trial;
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(ITERS - 1));
    assign root = root_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rad_q  <= radicand;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= rad_q << 2;
            rem_q  <= take ? (rem_sh - trial) : rem_sh;
            root_q <= (root_q << 1) | ITERS'(take);
            cnt_q  <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ray_sphere_nearest.sv
// Scans the sphere table for one ray and reports the nearest hit
// distance, index and colour over a valid/ready result handshake.
module ray_sphere_nearest
    import vtracer_pkg::*;
#(
    parameter  int N_OBJ     = 4,
    parameter  int T_W       = 10,
    parameter  int ISQ_ITERS = 8,
    localparam int AW        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              obj_we,
    input  logic [AW-1:0]     obj_addr,
    input  logic [OBJ_W-1:0]  obj_data,
    input  logic              obj_en,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [ORIG_W-1:0] ray_orig,
    input  logic [DIR_W-1:0]  ray_dir,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic              hit_any,
    output logic [T_W-1:0]    hit_t,
    output logic [AW-1:0]     hit_id,
    output logic [COL_W-1:0]  hit_color
);

    localparam int RW    = 2 * ISQ_ITERS;
    localparam int TMAXI = (1 << T_W) - 1;
    localparam logic [T_W-1:0] T_MAX = T_W'(TMAXI);

    state_t state, state_nx;

    logic [OBJ_W-1:0]  tbl_word [N_OBJ];
    logic [N_OBJ-1:0]  tbl_en;

    logic [ORIG_W-1:0] orig_q;
    logic [DIR_W-1:0]  dir_q;
    logic [AW-1:0]     idx;
    logic signed [31:0] tca_q;

    logic [T_W-1:0]    best_t;
    logic [AW-1:0]     best_id;
    logic [COL_W-1:0]  best_col;
    logic              found;

    logic              accept;
    logic              last_idx;

    logic [OBJ_W-1:0]  ent;
    logic              ent_en;
    logic signed [31:0] lx, ly, lz;
    logic signed [31:0] dx, dy, dz;
    logic signed [31:0] tca, ll, d2, r2;
    logic              cand;
    logic [RW-1:0]     radicand;

    logic              sq_start;
    logic              sq_busy;
    logic              sq_done;
    logic [ISQ_ITERS-1:0] thc;

    logic signed [31:0] t0, t1, tsel;
    logic              cmp_hit;
    logic [T_W-1:0]    t_sat;

    assign ray_ready = (state == S_IDLE) && !rst;
    assign hit_valid = (state == S_DONE);
    assign hit_any   = found;
    assign hit_t     = best_t;
    assign hit_id    = best_id;
    assign hit_color = best_col;

    assign accept   = ray_valid && ray_ready;
    assign last_idx = (idx == AW'(N_OBJ - 1));

    always_comb begin
        ent    = tbl_word[idx];
        ent_en = tbl_en[idx];
        lx = 32'(ent[CX_LSB +: XY_W]) - 32'(orig_q[OX_LSB +: XY_W]);
        ly = 32'(ent[CY_LSB +: XY_W]) - 32'(orig_q[OY_LSB +: XY_W]);
        lz = 32'(ent[CZ_LSB +: Z_W])  - 32'(orig_q[OZ_LSB +: Z_W]);
        dx = sext_dc(dir_q[DX_LSB +: DC_W]);
        dy = sext_dc(dir_q[DY_LSB +: DC_W]);
        dz = sext_dc(dir_q[DZ_LSB +: DC_W]);
        tca = (lx * dx + ly * dy + lz * dz) >>> Q_SHIFT;
        ll  = lx * lx + ly * ly + lz * lz;
        d2  = ll - tca * tca;
        if (d2 < 0) begin
            d2 = 0;
        end
        r2 = 32'(ent[RAD_LSB +: RAD_W]) * 32'(ent[RAD_LSB +: RAD_W]);
        cand = ent_en && (d2 <= r2);
        radicand = RW'(r2 - d2);
    end

    assign sq_start = (state == S_LOAD) && cand;

    isqrt_seq #(
        .ITERS(ISQ_ITERS)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (radicand),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (thc)
    );

    // far-side root covers an origin sitting inside the sphere
    always_comb begin
        t0      = tca_q - 32'(thc);
        t1      = tca_q + 32'(thc);
        cmp_hit = 1'b1;
        tsel    = t0;
        if (t0 < 0) begin
            tsel = t1;
            if (t1 < 0) begin
                cmp_hit = 1'b0;
            end
        end
        if (tsel > TMAXI - 1) begin
            t_sat = T_MAX - T_W'(1);
        end else begin
            t_sat = T_W'(tsel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = S_LOAD;
            S_LOAD: begin
                if (cand) begin
                    state_nx = S_SQRT;
                end else if (last_idx) begin
                    state_nx = S_DONE;
                end
            end
            S_SQRT: if (sq_done) state_nx = S_CMP;
            S_CMP:  state_nx = last_idx ? S_DONE : S_LOAD;
            S_DONE: if (hit_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orig_q   <= '0;
            dir_q    <= '0;
            idx      <= '0;
            tca_q    <= '0;
            best_t   <= T_MAX;
            best_id  <= '0;
            best_col <= '0;
            found    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        orig_q   <= ray_orig;
                        dir_q    <= ray_dir;
                        idx      <= '0;
                        best_t   <= T_MAX;
                        best_id  <= '0;
                        best_col <= '0;
                        found    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (cand) begin
                        tca_q <= tca;
                    end else if (!last_idx) begin
                        idx <= idx + AW'(1);
                    end
                end
                S_CMP: begin
                    if (cmp_hit && (t_sat < best_t)) begin
                        best_t   <= t_sat;
                        best_id  <= idx;
                        best_col <= ent[COL_LSB +: COL_W];
                        found    <= 1'b1;
                    end
                    if (!last_idx) begin
                        idx <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OBJ; i++) begin
                tbl_word[i] <= '0;
            end
            tbl_en <= '0;
        end else if (obj_we && (state == S_IDLE)) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (obj_addr == AW'(i)) begin
                    tbl_word[i] <= obj_data;
                    tbl_en[i]   <= obj_en;
                end
            end
        end
    end

endmodule
